// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Brief    : Shared encodings and constants for the iterative mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  // Datapath width and number of radix-2 iterations per operation
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  // MD_ctr operation encodings (11x is reserved and ignored)
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_step
// Brief    : One combinational radix-2 iteration shared by multiply
//            (shift-add, right shift) and divide (restoring, left shift).
//            Accumulator layout: upper half = partial product / remainder,
//            lower half = multiplier bits / dividend-then-quotient bits.
// Revision : 1.0 - initial release
// ============================================================================
module md_iter_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opnd_i,
  input  logic           is_div_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0]   mul_sum;   // partial product plus optional multiplicand, with carry
  logic [W:0]   rem_sh;    // remainder after shifting in the next dividend bit
  logic [W-1:0] rem_sub;   // trial remainder, valid only when rem_sh >= divisor
  logic         rem_ge;

  // Single iteration: add-then-shift-right for multiply, shift-then-subtract for divide
  always_comb begin
    mul_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
    rem_sh  = acc_i[2*W-1:W-1];
    rem_ge  = (rem_sh >= {1'b0, opnd_i});
    rem_sub = rem_sh[W-1:0] - opnd_i;
    if (is_div_i) begin
      if (rem_ge) begin
        acc_o = {rem_sub, acc_i[W-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[W-1:0], acc_i[W-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum[W:1], mul_sum[0], acc_i[W-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_unit
// Brief    : Iterative multiply/divide responder with architectural HI/LO.
//            32 CALC cycles plus one FIX cycle for sign correction; Busy is
//            decoded from the registered state. mthi/mtlo write in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module md_iter_unit #(
  parameter int WIDTH = md_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MD_ctr,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  output logic             Busy,
  output logic [WIDTH-1:0] HIO,
  output logic [WIDTH-1:0] LOO
);

  import md_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               sign_a_q;   // dividend/multiplicand was negative (signed ops only)
  logic               sign_b_q;   // divisor/multiplier was negative (signed ops only)

  logic               op_arith;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  md_iter_step #(
    .W (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (acc_d)
  );

  // Operand magnitudes for launch and sign-corrected results for the FIX edge
  always_comb begin
    op_arith  = (MD_ctr == MD_MULT) || (MD_ctr == MD_MULTU) ||
                (MD_ctr == MD_DIV)  || (MD_ctr == MD_DIVU);
    op_signed = (MD_ctr == MD_MULT) || (MD_ctr == MD_DIV);
    a_mag     = (op_signed && RD1[WIDTH-1]) ? (-RD1) : RD1;
    b_mag     = (op_signed && RD2[WIDTH-1]) ? (-RD2) : RD2;
    neg_res   = sign_a_q ^ sign_b_q;
    prod_fix  = neg_res ? (-acc_q) : acc_q;
    quo_fix   = neg_res ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix   = sign_a_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer: launch in IDLE, iterate in CALC, sign-correct and write back in FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (op_arith) begin
              // Both ops start with the rs magnitude in the low half and rt as the operand
              acc_q    <= {{WIDTH{1'b0}}, a_mag};
              opnd_q   <= b_mag;
              is_div_q <= MD_ctr[1];
              sign_a_q <= op_signed & RD1[WIDTH-1];
              sign_b_q <= op_signed & RD2[WIDTH-1];
              cnt_q    <= '0;
              state_q  <= ST_CALC;
            end else if (MD_ctr == MD_MTHI) begin
              hi_q <= RD1;
            end else if (MD_ctr == MD_MTLO) begin
              lo_q <= RD1;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (opnd_q != '0) begin
            // Divide by zero leaves HI/LO untouched
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_q != ST_IDLE);
  assign HIO  = hi_q;
  assign LOO  = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_iter_unit
// Brief    : Directed self-checking bench for md_iter_unit with
//            hand-computed HI/LO results and Busy-length checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_iter_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MD_ctr;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        Busy;
  logic [31:0] HIO;
  logic [31:0] LOO;

  int n_vec;
  int n_err;
  int cyc;
  int bad;

  md_iter_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MD_ctr (MD_ctr),
    .RD1    (RD1),
    .RD2    (RD2),
    .Busy   (Busy),
    .HIO    (HIO),
    .LOO    (LOO)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle Start at a falling edge; returns at the next falling edge
  task automatic start_op(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start  = 1'b1;
    MD_ctr = ctr;
    RD1    = a;
    RD2    = b;
    @(negedge clk);
    Start  = 1'b0;
    MD_ctr = 3'b111;
    RD1    = 32'h0;
    RD2    = 32'h0;
  endtask

  // Count falling edges with Busy high, bounded
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (Busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    Start  = 1'b0;
    MD_ctr = 3'b111;
    RD1    = 32'h0;
    RD2    = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_hi", HIO, 32'h0);
    chk("rst_lo", LOO, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // mult -2 * 3 = -6
    start_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(cyc);
    chk("mult_busy_len", cyc, 33);
    chk("mult_hi", HIO, 32'hFFFF_FFFF);
    chk("mult_lo", LOO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    start_op(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(cyc);
    chk("multu_busy_len", cyc, 33);
    chk("multu_hi", HIO, 32'h0000_0002);
    chk("multu_lo", LOO, 32'hFFFF_FFFA);

    // div -7 / 2 = -3 rem -1
    start_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc);
    chk("div_busy_len", cyc, 33);
    chk("div_lo", LOO, 32'hFFFF_FFFD);
    chk("div_hi", HIO, 32'hFFFF_FFFF);

    // divu 7 / 2 = 3 rem 1
    start_op(3'b011, 32'h0000_0007, 32'h0000_0002);
    wait_done(cyc);
    chk("divu_lo", LOO, 32'h0000_0003);
    chk("divu_hi", HIO, 32'h0000_0001);

    // mtlo / mthi then divide by zero leaves both untouched
    start_op(3'b101, 32'h0000_0022, 32'h0);
    chk("mtlo_lo", LOO, 32'h0000_0022);
    chk("mtlo_busy", {31'h0, Busy}, 32'h0);
    start_op(3'b100, 32'h0000_0011, 32'h0);
    chk("mthi_hi", HIO, 32'h0000_0011);
    start_op(3'b010, 32'h0000_0064, 32'h0000_0000);
    wait_done(cyc);
    chk("div0_busy_len", cyc, 33);
    chk("div0_hi", HIO, 32'h0000_0011);
    chk("div0_lo", LOO, 32'h0000_0022);

    // Signed overflow wraps
    start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("divovf_lo", LOO, 32'h8000_0000);
    chk("divovf_hi", HIO, 32'h0000_0000);

    // mthi visible next cycle, Busy never rises
    start_op(3'b100, 32'hDEAD_BEEF, 32'h0);
    chk("mthi2_hi", HIO, 32'hDEAD_BEEF);
    chk("mthi2_busy", {31'h0, Busy}, 32'h0);

    // Reserved encoding ignored
    start_op(3'b110, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("rsvd_busy", {31'h0, Busy}, 32'h0);
    chk("rsvd_hi", HIO, 32'hDEAD_BEEF);
    chk("rsvd_lo", LOO, 32'h8000_0000);

    // Protocol violation: mtlo pulsed mid-CALC of mult -3 * 7 = -21 is ignored
    start_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007);
    repeat (5) @(negedge clk);
    $display("note: protocol violation injected (Start while Busy)");
    Start  = 1'b1;
    MD_ctr = 3'b101;
    RD1    = 32'h0000_0005;
    @(negedge clk);
    Start  = 1'b0;
    MD_ctr = 3'b111;
    RD1    = 32'h0;
    wait_done(cyc);
    chk("viol_busy_len", cyc, 27);
    chk("viol_lo", LOO, 32'hFFFF_FFEB);
    chk("viol_hi", HIO, 32'hFFFF_FFFF);

    // Start at the FIX edge is ignored: multu 0x10001 * 0x10000 = 0x1_0001_0000
    start_op(3'b001, 32'h0001_0001, 32'h0001_0000);
    repeat (32) @(negedge clk);
    Start  = 1'b1;
    MD_ctr = 3'b100;
    RD1    = 32'h0000_AAAA;
    @(negedge clk);
    Start  = 1'b0;
    MD_ctr = 3'b111;
    RD1    = 32'h0;
    chk("fixedge_busy", {31'h0, Busy}, 32'h0);
    chk("fixedge_hi", HIO, 32'h0000_0001);
    chk("fixedge_lo", LOO, 32'h0001_0000);

    // Asynchronous reset at CALC cycle 10 of a mult
    start_op(3'b000, 32'h0000_1234, 32'h0000_0010);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'h0, Busy}, 32'h0);
    chk("arst_hi", HIO, 32'h0);
    chk("arst_lo", LOO, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HIO !== 32'h0 || LOO !== 32'h0) bad++;
    end
    chk("arst_no_resume", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Iterative multiply/divide responder serving the EX-stage Start/Busy/MD_ctr handshake and the HI/LO read path of the 5-stage pipeline.
- Accepts operands RD1/RD2 with an operation code and runs a radix-2 shift-add multiply or restoring divide over 32 cycles.
- Holds HI/LO as architectural registers and raises Busy so the stall unit freezes dependent instructions.
- Also services mthi/mtlo as single-cycle register writes.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is required to work.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request, qualified by MD_ctr.
- MD_ctr  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved.
- RD1  input  WIDTH  rs operand (multiplicand/dividend/mthi-mtlo data).
- RD2  input  WIDTH  rt operand (multiplier/divisor).
- Busy  output  1  high while an operation is in flight.
- HIO  output  WIDTH  HI register.
- LOO  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; Busy=0; HIO=0; LOO=0; counter=0.
  - Any in-flight operation is discarded, and none resumes after reset is released.
- States: IDLE, CALC, FIX. Busy = (state != IDLE), decoded from registered state only.
- IDLE, Start=1, MD_ctr in {000..011}, at that edge:
  - Latch magnitudes |RD1|, |RD2| (signed ops) or raw values (unsigned ops).
  - Latch the sign bits and the op.
  - Clear the accumulator and set counter=0; go to CALC.
- IDLE, Start=1, MD_ctr=100: HIO<=RD1 at that edge; Busy stays 0. MD_ctr=101: LOO<=RD1 likewise.
- IDLE, Start=1, MD_ctr=11x: ignored.
- CALC:
  - Multiply: one shift-add step per cycle on a 64-bit accumulator.
  - Divide: one restoring-subtract step per cycle (remainder WIDTH+1 bits).
  - counter increments each cycle; after the 32nd CALC cycle go to FIX.
- FIX (1 cycle), applying sign correction at the FIX edge:
  - mult: negate the 64-bit product iff sign(RD1)^sign(RD2).
  - div: negate the quotient iff the signs differ; the remainder takes the dividend's sign.
  - Result written: mult/multu {HIO,LOO}<=product; div/divu LOO<=quotient, HIO<=remainder.
  - Then go to IDLE.
- Latency: Busy is high for exactly 33 cycles, starting the cycle after the Start edge. New HIO/LOO are visible in the first cycle with Busy=0.
- HIO/LOO hold their old values throughout CALC/FIX.
- Divide by zero: the full 33-cycle Busy sequence still runs; HIO/LOO are left unchanged at FIX.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- Start while Busy: ignored for every MD_ctr value, including mthi/mtlo. The stall unit guarantees this never happens; verification flags it as a protocol violation.
- Start coincident with the FIX edge: ignored. Start is accepted only when state==IDLE.
- All arithmetic is modulo 2^WIDTH / 2^(2*WIDTH); no overflow flags.

Decomposition:
- Shared package md_pkg holds:
  - MD_ctr encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - The state encoding (ST_IDLE, ST_CALC, ST_FIX).
  - Constants WIDTH and ITER=32.
- One natural sub-module: md_iter_step, a combinational single-iteration datapath. It takes the accumulator, operand and op class, and returns the next accumulator. It is shared by the multiply and divide paths.
- The FSM, counter, sign capture and HI/LO registers stay in md_iter_unit.

Test Plan:
- mult RD1=0xFFFFFFFE, RD2=0x3 → Busy high 33 cycles; then HIO=0xFFFFFFFF, LOO=0xFFFFFFFA.
- multu RD1=0xFFFFFFFE, RD2=0x3 → HIO=0x00000002, LOO=0xFFFFFFFA after 33 Busy cycles.
- div RD1=0xFFFFFFF9 (-7), RD2=0x2 → LOO=0xFFFFFFFD, HIO=0xFFFFFFFF. divu 7/2 → LOO=0x3, HIO=0x1.
- Divide by zero and overflow:
  - mtlo 0x22 then mthi 0x11, then div RD2=0 → Busy 33 cycles; HIO=0x11 and LOO=0x22 unchanged.
  - div 0x80000000/0xFFFFFFFF → LOO=0x80000000, HIO=0.
- mthi RD1=0xDEADBEEF → HIO=0xDEADBEEF the next cycle, Busy never rises. A second Start (mtlo 0x5) pulsed mid-CALC of a mult → ignored; LOO equals the mult result.
- mult in flight:
  - Assert reset=0 at CALC cycle 10 → Busy=0, HIO=LOO=0 immediately (asynchronous).
  - After release, no result write ever occurs.
